vec_stream_reader: RTL and testbench



---
 rtl/vec_reader_pkg.sv | 35 +++
 rtl/vec_out_reg.sv | 45 ++++
 rtl/vec_stream_reader.sv | 167 ++++++++++++++++
 tb/tb_vec_stream_reader.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_reader_pkg.sv
//------------------------------------------------------------------------------
// Module   : vec_reader_pkg
// Brief    : Shared types and sizing helpers for the vector stream reader.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package vec_reader_pkg;

  // Sequencer states of the read-side replay engine.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    WRAP   = 2'd2,
    DRAIN  = 2'd3
  } rd_state_t;

  // Number of FIFO-width chunks making up one stored vector.
  function automatic int chunks_per_vec(input int vec_elements, input int bytes_per_read);
    return vec_elements / bytes_per_read;
  endfunction

  // Width of the chunk index counter (never narrower than one bit).
  function automatic int chunk_cnt_w(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

  // Width of the replay counter and the replay-count input.
  function automatic int rep_cnt_w(input int max_reps);
    return $clog2(max_reps + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vec_out_reg.sv
//------------------------------------------------------------------------------
// Module   : vec_out_reg
// Brief    : One-entry valid/ready output register carrying a data chunk plus
//            its end-of-replay and end-of-pass markers. Holds its contents
//            stable while valid and not accepted downstream.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vec_out_reg #(
  parameter int BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [BYTES-1:0][7:0] push_data,
  input  logic                  push_last,
  input  logic                  push_final,
  input  logic                  pop_ready,
  output logic [BYTES-1:0][7:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  out_final
);

  // Load a new chunk when pushed; otherwise empty once the consumer accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_final <= 1'b0;
    end else if (push) begin
      out_data  <= push_data;
      out_valid <= 1'b1;
      out_last  <= push_last;
      out_final <= push_final;
    end else if (pop_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vec_stream_reader.sv
//------------------------------------------------------------------------------
// Module   : vec_stream_reader
// Brief    : Drains one stored vector from the vector FIFO in FIFO-width
//            chunks and replays it a programmable number of times, using the
//            FIFO read-advance and rewind controls. Chunks leave on a
//            valid/ready stream with per-replay (last) and per-pass (final)
//            markers.
// Options  : VEC_READER_PERF_EN adds stall_cnt_out, a saturating count of
//            cycles with m_valid_out && !m_ready_in since the last start.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

import vec_reader_pkg::*;

module vec_stream_reader #(
  parameter int VEC_ELEMENTS   = 16,
  parameter int BYTES_PER_READ = 4,
  parameter int MAX_REPS       = 256
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           start_in,
  input  logic [rep_cnt_w(MAX_REPS)-1:0] reps_in,
  input  logic                           vec_ready_in,
  input  logic [BYTES_PER_READ-1:0][7:0] fifo_rd_data_in,
  output logic                           fifo_rd_en_out,
  output logic                           fifo_wrap_rd_out,
  output logic [BYTES_PER_READ-1:0][7:0] m_data_out,
  output logic                           m_valid_out,
  input  logic                           m_ready_in,
  output logic                           m_last_out,
  output logic                           m_final_out,
`ifdef VEC_READER_PERF_EN
  output logic [31:0]                    stall_cnt_out,
`endif
  output logic                           busy_out,
  output logic                           done_out
);

  localparam int C  = chunks_per_vec(VEC_ELEMENTS, BYTES_PER_READ);
  localparam int CW = chunk_cnt_w(C);
  localparam int RW = rep_cnt_w(MAX_REPS);
  localparam logic [CW-1:0] LAST_CHUNK = CW'(C - 1);

  rd_state_t       state;
  rd_state_t       state_nxt;
  logic [CW-1:0]   chunk_cnt;
  logic [RW-1:0]   rep_cnt;
  logic [RW-1:0]   reps;
  logic            done_q;
  logic            load;
  logic            push;
  logic            is_last_chunk;
  logic            is_final_rep;
  logic            start_ok;
  logic            handshake;

  assign load          = !m_valid_out || m_ready_in;
  assign is_last_chunk = (chunk_cnt == LAST_CHUNK);
  assign is_final_rep  = (rep_cnt == (reps - RW'(1)));
  assign start_ok      = start_in && vec_ready_in;
  assign handshake     = m_valid_out && m_ready_in;
  assign busy_out      = (state != IDLE);
  assign done_out      = done_q;

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next-state and FIFO control; the read advances only when the output
  // register can take the chunk, so backpressure stalls the FIFO.
  always_comb begin
    state_nxt        = state;
    fifo_rd_en_out   = 1'b0;
    fifo_wrap_rd_out = 1'b0;
    push             = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok && (reps_in != '0)) state_nxt = STREAM;
      end
      STREAM: begin
        if (load) begin
          fifo_rd_en_out = 1'b1;
          push           = 1'b1;
          if (is_last_chunk) state_nxt = is_final_rep ? DRAIN : WRAP;
        end
      end
      WRAP: begin
        fifo_wrap_rd_out = 1'b1;
        state_nxt        = STREAM;
      end
      DRAIN: begin
        if (handshake) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Chunk/replay counters, latched replay count and the done pulse.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      chunk_cnt <= '0;
      rep_cnt   <= '0;
      reps      <= '0;
      done_q    <= 1'b0;
    end else begin
      // A zero-replay start completes immediately without touching the FIFO.
      done_q <= ((state == IDLE) && start_ok && (reps_in == '0)) ||
                ((state == DRAIN) && handshake);
      case (state)
        IDLE: begin
          if (start_ok && (reps_in != '0)) begin
            reps      <= reps_in;
            chunk_cnt <= '0;
            rep_cnt   <= '0;
          end
        end
        STREAM: begin
          if (load) chunk_cnt <= chunk_cnt + CW'(1);
        end
        WRAP: begin
          rep_cnt   <= rep_cnt + RW'(1);
          chunk_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  vec_out_reg #(
    .BYTES (BYTES_PER_READ)
  ) u_out_reg (
    .clk        (clk_in),
    .rst_n      (rst_n_in),
    .push       (push),
    .push_data  (fifo_rd_data_in),
    .push_last  (is_last_chunk),
    .push_final (is_last_chunk && is_final_rep),
    .pop_ready  (m_ready_in),
    .out_data   (m_data_out),
    .out_valid  (m_valid_out),
    .out_last   (m_last_out),
    .out_final  (m_final_out)
  );

`ifdef VEC_READER_PERF_EN
  logic [31:0] stall_cnt;
  assign stall_cnt_out = stall_cnt;

  // Saturating count of stalled output cycles, cleared on an accepted start.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stall_cnt <= '0;
    end else if ((state == IDLE) && start_ok) begin
      stall_cnt <= '0;
    end else if (m_valid_out && !m_ready_in && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vec_stream_reader.sv
//------------------------------------------------------------------------------
// Module   : tb_vec_stream_reader
// Brief    : Self-checking bench for vec_stream_reader with a simple vector
//            FIFO stand-in (byte at address a holds a[7:0]) and a chunk-list
//            model of what each pass must emit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vec_stream_reader;

  localparam int VE  = 8;
  localparam int BPR = 4;
  localparam int MR  = 256;
  localparam int C   = VE / BPR;
  localparam int RW  = $clog2(MR + 1);

  logic                clk_in       = 1'b0;
  logic                rst_n_in     = 1'b0;
  logic                start_in     = 1'b0;
  logic [RW-1:0]       reps_in      = '0;
  logic                vec_ready_in = 1'b1;
  logic [BPR-1:0][7:0] fifo_rd_data_in;
  logic                fifo_rd_en_out;
  logic                fifo_wrap_rd_out;
  logic [BPR-1:0][7:0] m_data_out;
  logic                m_valid_out;
  logic                m_ready_in   = 1'b1;
  logic                m_last_out;
  logic                m_final_out;
  logic                busy_out;
  logic                done_out;
`ifdef VEC_READER_PERF_EN
  logic [31:0]         stall_cnt_out;
`endif

  vec_stream_reader #(
    .VEC_ELEMENTS   (VE),
    .BYTES_PER_READ (BPR),
    .MAX_REPS       (MR)
  ) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .start_in         (start_in),
    .reps_in          (reps_in),
    .vec_ready_in     (vec_ready_in),
    .fifo_rd_data_in  (fifo_rd_data_in),
    .fifo_rd_en_out   (fifo_rd_en_out),
    .fifo_wrap_rd_out (fifo_wrap_rd_out),
    .m_data_out       (m_data_out),
    .m_valid_out      (m_valid_out),
    .m_ready_in       (m_ready_in),
    .m_last_out       (m_last_out),
    .m_final_out      (m_final_out),
`ifdef VEC_READER_PERF_EN
    .stall_cnt_out    (stall_cnt_out),
`endif
    .busy_out         (busy_out),
    .done_out         (done_out)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- FIFO stand-in: read pointer with advance/rewind --------
  int ptr;
  bit adv_p, wrap_p;
  always @(negedge clk_in) begin
    adv_p  = fifo_rd_en_out;
    wrap_p = fifo_wrap_rd_out;
  end
  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) ptr <= 0;
    else           ptr <= ptr + (adv_p ? BPR : 0) - (wrap_p ? VE : 0);
  end
  always_comb begin
    for (int k = 0; k < BPR; k++) fifo_rd_data_in[k] = 8'(ptr + k);
  end

  // ---------------- Ready driver -------------------------------------------
  bit toggle_mode = 1'b0;
  always @(posedge clk_in) begin
    #1;
    m_ready_in = toggle_mode ? ~m_ready_in : 1'b1;
  end

  // ---------------- Model: list of chunks each pass must emit --------------
  typedef struct {
    logic [31:0] d;
    logic        l;
    logic        f;
  } exp_t;
  exp_t q[$];
  int   base = 0;

  function automatic void push_pass(input int b, input int r);
    exp_t e;
    for (int rep = 0; rep < r; rep++) begin
      for (int c = 0; c < C; c++) begin
        for (int k = 0; k < BPR; k++) e.d[8*k +: 8] = 8'(b + BPR*c + k);
        e.l = (c == C - 1);
        e.f = (c == C - 1) && (rep == r - 1);
        q.push_back(e);
      end
    end
  endfunction

  // ---------------- Compare process ----------------------------------------
  int rd_cnt = 0, wrap_cnt = 0, done_cnt = 0, hs_cnt = 0, valid_cnt = 0, stall_seen = 0;
  bit          hold_pending = 1'b0;
  logic [31:0] held_d;
  logic        held_l, held_f;

  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      hold_pending = 1'b0;
    end else begin
      if (fifo_rd_en_out && fifo_wrap_rd_out) check("rd_and_wrap_exclusive", 1, 0);
      if (fifo_rd_en_out) rd_cnt++;
      if (fifo_wrap_rd_out) wrap_cnt++;
      if (done_out) begin
        done_cnt++;
        check("busy_low_with_done", busy_out, 0);
      end
      if (hold_pending) begin
        check("hold_valid", m_valid_out, 1);
        check("hold_data", m_data_out, held_d);
        check("hold_flags", {m_last_out, m_final_out}, {held_l, held_f});
        hold_pending = 1'b0;
      end
      if (m_valid_out) begin
        valid_cnt++;
        if (!m_ready_in) begin
          stall_seen++;
          hold_pending = 1'b1;
          held_d = m_data_out;
          held_l = m_last_out;
          held_f = m_final_out;
        end else begin
          hs_cnt++;
          if (q.size() == 0) begin
            check("unexpected_chunk", 1, 0);
          end else begin
            exp_t e;
            e = q.pop_front();
            check("chunk_data", m_data_out, e.d);
            check("chunk_last", m_last_out, e.l);
            check("chunk_final", m_final_out, e.f);
          end
        end
      end
    end
  end

  // ---------------- Stimulus helpers ---------------------------------------
  task automatic start_pass(input int r, input bit accept);
    start_in = 1'b1;
    reps_in  = RW'(r);
    if (accept) begin
      push_pass(base, r);
      if (r > 0) base += VE;
      stall_seen = 0;
    end
    @(posedge clk_in); #1;
    start_in = 1'b0;
  endtask

  task automatic wait_done(input int cyc0, input int max, output int cyc);
    cyc = cyc0;
    while (!done_out && cyc < max) begin
      @(posedge clk_in); #1;
      cyc++;
    end
    if (!done_out) check("done_timeout", 0, 1);
  endtask

  task automatic settle();
    @(posedge clk_in); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int cyc;
  int s_rd, s_wrap, s_done, s_hs, s_valid;

  task automatic snap();
    s_rd = rd_cnt; s_wrap = wrap_cnt; s_done = done_cnt; s_hs = hs_cnt; s_valid = valid_cnt;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_outputs", {fifo_rd_en_out, fifo_wrap_rd_out, m_valid_out, m_last_out,
                          m_final_out, busy_out, done_out}, 7'b0);
    check("rst_data", m_data_out, 0);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    settle();

    // Test 1: reps=3, full-rate ready; pinned timing and first chunk.
    snap();
    start_pass(3, 1);
    check("t1_rd_en_cycle1", fifo_rd_en_out, 1);
    check("t1_valid_cycle1", m_valid_out, 0);
    settle();
    check("t1_valid_cycle2", m_valid_out, 1);
    check("t1_first_chunk", m_data_out, 32'h03020100);
    wait_done(2, 100, cyc);
    check("t1_done_cycle", cyc, 10);
    settle();
    check("t1_chunks", hs_cnt - s_hs, 6);
    check("t1_wraps", wrap_cnt - s_wrap, 2);
    check("t1_dones", done_cnt - s_done, 1);
    check("t1_reads", rd_cnt - s_rd, 6);
    check("t1_queue_empty", q.size(), 0);

    // Test 2: ready toggling 1010...
    snap();
    toggle_mode = 1'b1;
    start_pass(3, 1);
    wait_done(1, 200, cyc);
    toggle_mode = 1'b0;
    settle();
    check("t2_chunks", hs_cnt - s_hs, 6);
    check("t2_wraps", wrap_cnt - s_wrap, 2);
    check("t2_dones", done_cnt - s_done, 1);
    check("t2_queue_empty", q.size(), 0);
    check("t2_stalls_seen", stall_seen > 0, 1);
`ifdef VEC_READER_PERF_EN
    check("t2_stall_cnt", stall_cnt_out, stall_seen);
`endif

    // Test 3: reps=0 completes next cycle with no FIFO access.
    snap();
    start_pass(0, 1);
    check("t3_done_cycle1", done_out, 1);
    check("t3_busy", busy_out, 0);
    repeat (4) settle();
    check("t3_no_reads", rd_cnt - s_rd, 0);
    check("t3_no_wraps", wrap_cnt - s_wrap, 0);
    check("t3_no_valid", valid_cnt - s_valid, 0);
    check("t3_dones", done_cnt - s_done, 1);

    // Test 4: start while no vector available is ignored.
    snap();
    vec_ready_in = 1'b0;
    start_pass(2, 0);
    for (int i = 0; i < 3; i++) begin
      check("t4_busy_low", busy_out, 0);
      settle();
    end
    check("t4_no_reads", rd_cnt - s_rd, 0);
    check("t4_no_done", done_cnt - s_done, 0);
    vec_ready_in = 1'b1;

    // Test 5: back-to-back passes, second with a stray mid-pass start.
    snap();
    start_pass(1, 1);
    wait_done(1, 100, cyc);
    start_pass(2, 1);
    check("t5_busy_after_b2b", busy_out, 1);
    settle(); settle();
    start_pass(5, 0);
    wait_done(4, 100, cyc);
    settle(); settle();
    check("t5_chunks", hs_cnt - s_hs, 6);
    check("t5_wraps", wrap_cnt - s_wrap, 1);
    check("t5_dones", done_cnt - s_done, 2);
    check("t5_queue_empty", q.size(), 0);
    check("t5_idle", busy_out, 0);

    // Test 6: reset during WRAP of a reps=4 pass, then a fresh reps=1 pass.
    snap();
    start_pass(4, 1);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk_in);
        seen = fifo_wrap_rd_out;
      end
      check("t6_wrap_reached", seen, 1);
    end
    #2 rst_n_in = 1'b0;
    #1;
    check("t6_rst_outputs", {fifo_rd_en_out, fifo_wrap_rd_out, m_valid_out, m_last_out,
                             m_final_out, busy_out, done_out}, 7'b0);
    check("t6_rst_data", m_data_out, 0);
    q.delete();
    base = 0;
    repeat (2) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    settle();
    check("t6_no_done", done_cnt - s_done, 0);
    snap();
    start_pass(1, 1);
    settle();
    check("t6_first_chunk", m_data_out, 32'h03020100);
    wait_done(2, 100, cyc);
    settle();
    check("t6_chunks", hs_cnt - s_hs, 2);
    check("t6_dones", done_cnt - s_done, 1);
    check("t6_queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
